// File: rtl/n64_poll_sequencer.sv
// Probe/poll sequencer for one N64 controller port: issues INFO once, then POLL
// periodically through the serial command writer, and decodes the reply from the data line.
module n64_poll_sequencer #(
  parameter int          POLL_PERIOD    = 100000,
  parameter int          SAMPLE_OFFSET  = 200,
  parameter int          RX_TIMEOUT     = 2000,
  parameter int          TX_START_LIMIT = 4,
  parameter logic [15:0] DEVICE_ID      = 16'h0500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        data_in,
  input  logic        wr_busy,
  output logic [7:0]  wr_command_byte,
  output logic        wr_en,
  output logic [31:0] buttons,
  output logic        buttons_valid,
  output logic        present,
  output logic        error
);

  // Writer handshake: wr_en is a one-cycle request with wr_command_byte stable;
  // the writer accepts by raising wr_busy and completes by dropping it.

  localparam int PW = $clog2(POLL_PERIOD + 1);
  localparam int EW = $clog2(SAMPLE_OFFSET + 1) + 1;
  localparam int TW = $clog2(RX_TIMEOUT + 1);
  localparam int XW = $clog2(TX_START_LIMIT + 1);

  localparam logic [PW-1:0] PERIOD_LAST  = PW'(POLL_PERIOD - 1);
  localparam logic [EW-1:0] SAMPLE_AT    = EW'(SAMPLE_OFFSET);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(RX_TIMEOUT - 1);
  localparam logic [XW-1:0] TX_LAST      = XW'(TX_START_LIMIT - 1);
  localparam logic [7:0]    CMD_INFO     = 8'h00;
  localparam logic [7:0]    CMD_POLL     = 8'h01;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_PERIOD, S_SEND, S_TX_START, S_TX_DONE, S_RX, S_EVAL
  } state_t;

  typedef enum logic {MODE_INFO, MODE_POLL} mode_t;

  state_t        state_q, state_d;
  mode_t         mode_q, mode_d;
  logic [7:0]    cmd_q, cmd_d;
  logic          sync1_q, sync2_q, prev_q;
  logic          fall;
  logic [EW-1:0] ec_q, ec_d;
  logic          armed_q, armed_d;
  logic [TW-1:0] to_q, to_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [XW-1:0] tx_q, tx_d;
  logic [5:0]    bit_q, bit_d;
  logic [31:0]   shift_q, shift_d;
  logic [31:0]   buttons_q, buttons_d;
  logic          bvalid_q, bvalid_d;
  logic          present_q, present_d;
  logic          error_q, error_d;
  logic [7:0]    mode_cmd;
  logic [5:0]    last_bit;
  logic          sample;

  // Idle line is high, so the synchronizer resets to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= data_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fall = prev_q & ~sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mode_q    <= MODE_INFO;
      cmd_q     <= 8'h00;
      ec_q      <= '0;
      armed_q   <= 1'b0;
      to_q      <= '0;
      pc_q      <= '0;
      tx_q      <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      buttons_q <= '0;
      bvalid_q  <= 1'b0;
      present_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cmd_q     <= cmd_d;
      ec_q      <= ec_d;
      armed_q   <= armed_d;
      to_q      <= to_d;
      pc_q      <= pc_d;
      tx_q      <= tx_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      buttons_q <= buttons_d;
      bvalid_q  <= bvalid_d;
      present_q <= present_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cmd_d     = cmd_q;
    ec_d      = ec_q;
    armed_d   = armed_q;
    to_d      = to_q;
    pc_d      = pc_q;
    tx_d      = tx_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    buttons_d = buttons_q;
    present_d = present_q;
    bvalid_d  = 1'b0;
    error_d   = 1'b0;
    sample    = 1'b0;
    mode_cmd  = (mode_q == MODE_POLL) ? CMD_POLL : CMD_INFO;
    last_bit  = (mode_q == MODE_POLL) ? 6'd31 : 6'd23;

    case (state_q)
      S_IDLE: begin
        if (enable && !wr_busy) begin
          state_d = S_SEND;
          cmd_d   = mode_cmd;
        end
      end
      S_WAIT_PERIOD: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (pc_q == PERIOD_LAST) begin
          state_d = S_SEND;
          cmd_d   = mode_cmd;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      S_SEND: begin
        // The wr_en cycle counts as the first of the allowed start cycles.
        state_d = S_TX_START;
        tx_d    = XW'(1);
      end
      S_TX_START: begin
        if (wr_busy) begin
          state_d = S_TX_DONE;
        end else if (tx_q == TX_LAST) begin
          error_d   = 1'b1;
          present_d = 1'b0;
          mode_d    = MODE_INFO;
          state_d   = S_WAIT_PERIOD;
        end else begin
          tx_d = tx_q + 1'b1;
        end
      end
      S_TX_DONE: begin
        if (!wr_busy) begin
          state_d = S_RX;
          bit_d   = '0;
          shift_d = '0;
          to_d    = '0;
          ec_d    = '0;
          armed_d = 1'b0;
        end
      end
      S_RX: begin
        // A new falling edge always re-arms the sample point, dropping any pending bit.
        if (fall) begin
          to_d    = '0;
          ec_d    = EW'(1);
          armed_d = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
          if (armed_q) begin
            if (ec_q == SAMPLE_AT) begin
              sample  = 1'b1;
              armed_d = 1'b0;
            end else begin
              ec_d = ec_q + 1'b1;
            end
          end
        end
        if (sample) begin
          shift_d = {shift_q[30:0], sync2_q};
          bit_d   = bit_q + 1'b1;
        end
        if (sample && (bit_q == last_bit)) begin
          state_d = S_EVAL;
        end else if (!fall && (to_q == TIMEOUT_LAST)) begin
          error_d   = 1'b1;
          present_d = 1'b0;
          buttons_d = '0;
          mode_d    = MODE_INFO;
          state_d   = S_WAIT_PERIOD;
        end
      end
      S_EVAL: begin
        if (mode_q == MODE_INFO) begin
          if (shift_q[23:8] == DEVICE_ID) begin
            present_d = 1'b1;
            mode_d    = MODE_POLL;
          end else begin
            error_d   = 1'b1;
            present_d = 1'b0;
          end
        end else begin
          buttons_d = shift_q;
          bvalid_d  = 1'b1;
        end
        state_d = S_WAIT_PERIOD;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_WAIT_PERIOD) pc_d = '0;
  end

  assign wr_en           = (state_q == S_SEND);
  assign wr_command_byte = cmd_q;
  assign buttons         = buttons_q;
  assign buttons_valid   = bvalid_q;
  assign present         = present_q;
  assign error           = error_q;

endmodule
